// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared PC-mux select and hazard FSM state types for the pipeline control path.
// pcmux re-exports the select type under the name the datapath ports use.
package rv32i_types;
    typedef enum logic [1:0] {
        pc_plus4 = 2'b00,
        alu_out  = 2'b01,
        alu_mod2 = 2'b10,
        btb_pc   = 2'b11
    } pcmux_sel_t;

    typedef enum logic {
        RUN        = 1'b0,
        REDIR_PEND = 1'b1
    } hazard_state_t;
endpackage

package pcmux;
    typedef rv32i_types::pcmux_sel_t pcmux_sel_t;
endpackage

// File: rtl/hazard_ctrl_unit_perf.sv
// Saturating performance counter: holds at all-ones, clr wins over inc.
// Latency: one cycle from inc/clr to count; no backpressure.
module perf_sat_counter #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    output logic [PERF_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: stalls, flushes and PC redirects, with a pending-redirect FSM.
// Control outputs are combinational from inputs and state; counters update one cycle later.
module hazard_ctrl_unit
    import rv32i_types::*;
#(
    parameter int N_STAGES = 5,
    parameter int PERF_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_stall,
    input  logic                 dec_stall,
    input  logic                 mem_stall,
    input  logic                 mispredict,
    input  pcmux::pcmux_sel_t    ex_pcmux_sel,
    input  logic [1:0]           btb_flag,
    input  logic                 perf_clr,
    output logic                 load_pc,
    output pcmux::pcmux_sel_t    pcmux_sel,
    output logic [N_STAGES-2:0]  load_stage,
    output logic                 flush_if,
    output logic                 flush_id,
    output logic [PERF_W-1:0]    cnt_if,
    output logic [PERF_W-1:0]    cnt_dec,
    output logic [PERF_W-1:0]    cnt_mem,
    output logic [PERF_W-1:0]    cnt_redir
);
    hazard_state_t state, state_next;
    pcmux_sel_t    pend_sel, pend_sel_next;
    logic          inc_if, inc_dec, inc_mem, inc_redir;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pend_sel <= pc_plus4;
        end else begin
            state    <= state_next;
            pend_sel <= pend_sel_next;
        end
    end

    always_comb begin
        load_pc       = 1'b1;
        load_stage    = '1;
        flush_if      = 1'b0;
        flush_id      = 1'b0;
        pcmux_sel     = pc_plus4;
        state_next    = state;
        pend_sel_next = pend_sel;
        inc_if        = 1'b0;
        inc_dec       = 1'b0;
        inc_mem       = 1'b0;
        inc_redir     = 1'b0;

        if (rst) begin
            load_pc  = 1'b0;
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else if (mem_stall) begin
            load_pc    = 1'b0;
            load_stage = '0;
            inc_mem    = 1'b1;
        end else if (state == REDIR_PEND) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
            if (if_stall) begin
                load_pc = 1'b0;
                inc_if  = 1'b1;
            end else begin
                pcmux_sel  = pend_sel;
                inc_redir  = 1'b1;
                state_next = RUN;
            end
        end else if (mispredict) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
            if (if_stall) begin
                // Fetch can't take the redirect yet; park it. This cycle is still a fetch stall.
                load_pc       = 1'b0;
                pend_sel_next = ex_pcmux_sel;
                state_next    = REDIR_PEND;
                inc_if        = 1'b1;
            end else begin
                pcmux_sel = ex_pcmux_sel;
                inc_redir = 1'b1;
            end
        end else if (dec_stall) begin
            load_pc       = 1'b0;
            load_stage[0] = 1'b0;
            flush_id      = 1'b1;
            inc_dec       = 1'b1;
        end else if (if_stall) begin
            load_pc  = 1'b0;
            flush_if = 1'b1;
            inc_if   = 1'b1;
        end else if (btb_flag == 2'b11) begin
            pcmux_sel = btb_pc;
        end
    end

    perf_sat_counter #(.PERF_W(PERF_W)) u_cnt_if (
        .clk(clk), .rst(rst), .inc(inc_if), .clr(perf_clr), .count(cnt_if)
    );
    perf_sat_counter #(.PERF_W(PERF_W)) u_cnt_dec (
        .clk(clk), .rst(rst), .inc(inc_dec), .clr(perf_clr), .count(cnt_dec)
    );
    perf_sat_counter #(.PERF_W(PERF_W)) u_cnt_mem (
        .clk(clk), .rst(rst), .inc(inc_mem), .clr(perf_clr), .count(cnt_mem)
    );
    perf_sat_counter #(.PERF_W(PERF_W)) u_cnt_redir (
        .clk(clk), .rst(rst), .inc(inc_redir), .clr(perf_clr), .count(cnt_redir)
    );
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios then random traffic, every cycle
// compared against an event-classifying reference model with 4-bit counters.
module tb_hazard_ctrl_unit;
    import rv32i_types::*;

    localparam int NS = 5;
    localparam int PW = 4;
    localparam int CMAX = (1 << PW) - 1;

    logic clk = 1'b0;
    logic rst, if_stall, dec_stall, mem_stall, mispredict, perf_clr;
    pcmux_sel_t ex_pcmux_sel;
    logic [1:0] btb_flag;
    logic load_pc, flush_if, flush_id;
    pcmux_sel_t pcmux_sel;
    logic [NS-2:0] load_stage;
    logic [PW-1:0] cnt_if, cnt_dec, cnt_mem, cnt_redir;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.N_STAGES(NS), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .if_stall(if_stall), .dec_stall(dec_stall),
        .mem_stall(mem_stall), .mispredict(mispredict), .ex_pcmux_sel(ex_pcmux_sel),
        .btb_flag(btb_flag), .perf_clr(perf_clr), .load_pc(load_pc),
        .pcmux_sel(pcmux_sel), .load_stage(load_stage), .flush_if(flush_if),
        .flush_id(flush_id), .cnt_if(cnt_if), .cnt_dec(cnt_dec),
        .cnt_mem(cnt_mem), .cnt_redir(cnt_redir)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a redirect is either pending or not, plus the counters as plain ints.
    typedef enum {E_RST, E_MEM, E_RNOW, E_RDEFER, E_PWAIT, E_PFIRE, E_DEC, E_IF, E_BTB, E_IDLE} ev_t;
    bit         m_pend;
    pcmux_sel_t m_psel;
    int         m_if, m_dec, m_mem, m_redir;

    function automatic int sat_inc(input int v, input bit hit);
        return (hit && v < CMAX) ? v + 1 : v;
    endfunction

    task automatic cyc(input logic r, input logic ms, input logic mp, input logic ds,
                       input logic is, input pcmux_sel_t ex, input logic [1:0] bf,
                       input logic pc);
        ev_t ev;
        logic [31:0] e_sel;
        bit e_lpc, e_fif, e_fid;
        logic [NS-2:0] e_stage;
        rst = r; mem_stall = ms; mispredict = mp; dec_stall = ds;
        if_stall = is; ex_pcmux_sel = ex; btb_flag = bf; perf_clr = pc;
        #1;
        if (r)             ev = E_RST;
        else if (ms)       ev = E_MEM;
        else if (m_pend)   ev = is ? E_PWAIT : E_PFIRE;
        else if (mp)       ev = is ? E_RDEFER : E_RNOW;
        else if (ds)       ev = E_DEC;
        else if (is)       ev = E_IF;
        else if (bf == 2'b11) ev = E_BTB;
        else               ev = E_IDLE;

        e_sel   = (ev == E_RNOW) ? 32'(ex) : (ev == E_PFIRE) ? 32'(m_psel) :
                  (ev == E_BTB) ? 32'(btb_pc) : 32'(pc_plus4);
        e_lpc   = ev inside {E_RNOW, E_PFIRE, E_BTB, E_IDLE};
        e_stage = (ev == E_MEM) ? '0 : (ev == E_DEC) ? {{(NS-2){1'b1}}, 1'b0} : '1;
        e_fif   = ev inside {E_RST, E_RNOW, E_RDEFER, E_PWAIT, E_PFIRE, E_IF};
        e_fid   = ev inside {E_RST, E_RNOW, E_RDEFER, E_PWAIT, E_PFIRE, E_DEC};

        chk("load_pc", 32'(load_pc), 32'(e_lpc));
        chk("pcmux_sel", 32'(pcmux_sel), e_sel);
        chk("load_stage", 32'(load_stage), 32'(e_stage));
        chk("flush_if", 32'(flush_if), 32'(e_fif));
        chk("flush_id", 32'(flush_id), 32'(e_fid));
        chk("state", 32'(dut.state), 32'(m_pend));
        chk("cnt_if", 32'(cnt_if), 32'(m_if));
        chk("cnt_dec", 32'(cnt_dec), 32'(m_dec));
        chk("cnt_mem", 32'(cnt_mem), 32'(m_mem));
        chk("cnt_redir", 32'(cnt_redir), 32'(m_redir));

        @(posedge clk);
        if (r || pc) begin
            m_if = 0; m_dec = 0; m_mem = 0; m_redir = 0;
        end else begin
            m_if    = sat_inc(m_if, ev inside {E_IF, E_PWAIT, E_RDEFER});
            m_dec   = sat_inc(m_dec, ev == E_DEC);
            m_mem   = sat_inc(m_mem, ev == E_MEM);
            m_redir = sat_inc(m_redir, ev inside {E_RNOW, E_PFIRE});
        end
        if (r) begin
            m_pend = 0; m_psel = pc_plus4;
        end else if (ev == E_RDEFER) begin
            m_pend = 1; m_psel = ex;
        end else if (ev == E_PFIRE) begin
            m_pend = 0;
        end
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, pc_plus4, 2'b00, 0);
    endtask

    initial begin
        rst = 1; if_stall = 0; dec_stall = 0; mem_stall = 0; mispredict = 0;
        perf_clr = 0; ex_pcmux_sel = pc_plus4; btb_flag = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        m_pend = 0; m_psel = pc_plus4;
        m_if = 0; m_dec = 0; m_mem = 0; m_redir = 0;

        // Reset outputs, then immediate redirect from RUN
        cyc(1, 0, 0, 0, 0, pc_plus4, 2'b11, 0);
        cyc(0, 0, 1, 0, 0, alu_out, 2'b00, 0);
        chk("redir_now_cnt", 32'(cnt_redir), 32'd1);
        idle();

        // Redirect deferred by 3 cycles of fetch stall (mispredict held and ignored while pending)
        repeat (3) cyc(0, 0, 1, 0, 1, alu_mod2, 2'b00, 0);
        chk("pend_state", 32'(dut.state), 32'(REDIR_PEND));
        cyc(0, 0, 0, 0, 0, pc_plus4, 2'b00, 0);
        chk("pend_if_cnt", 32'(cnt_if), 32'd3);
        chk("pend_redir_cnt", 32'(cnt_redir), 32'd2);

        // mem_stall freezes a pending redirect, which still fires afterwards
        cyc(0, 0, 1, 0, 1, alu_out, 2'b00, 0);
        repeat (2) cyc(0, 1, 0, 0, 1, pc_plus4, 2'b11, 0);
        cyc(0, 0, 0, 0, 1, pc_plus4, 2'b00, 0);
        cyc(0, 0, 0, 0, 0, pc_plus4, 2'b11, 0);

        // Load-use stall beats a BTB hit
        cyc(0, 0, 0, 1, 1, pc_plus4, 2'b11, 0);
        cyc(0, 0, 0, 0, 0, pc_plus4, 2'b11, 0);

        // Reset while pending discards the redirect
        cyc(0, 0, 1, 0, 1, alu_out, 2'b00, 0);
        cyc(1, 0, 0, 0, 1, pc_plus4, 2'b00, 0);
        idle();
        chk("rst_pend_redir", 32'(cnt_redir), 32'd0);

        // Counter saturation and clear
        cyc(0, 0, 0, 0, 0, pc_plus4, 2'b00, 1);
        repeat (20) cyc(0, 1, 0, 0, 0, pc_plus4, 2'b00, 0);
        chk("sat_mem", 32'(cnt_mem), 32'(CMAX));
        cyc(0, 1, 0, 0, 0, pc_plus4, 2'b00, 1);
        chk("clr_mem", 32'(cnt_mem), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0), pcmux_sel_t'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), ($urandom_range(0, 24) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
